// File: rtl/dispatch_pkg.sv
// Shared defaults and arbiter state encoding for the dispatch RAM arbiter.
package dispatch_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 17;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    RUN    = 2'd1,
    BUSACK = 2'd2
  } state_t;
endpackage

// File: rtl/dispatch_arbiter_if.sv
// CPU dispatch-read and bus request/ack signals shared by the arbiter and its requesters.
interface dispatch_arbiter_if
  import dispatch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cpu_rd;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_stall;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_data;

  logic              bus_req;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output cpu_rd, cpu_addr, bus_req, bus_write, bus_addr, bus_wdata,
    input  cpu_stall, cpu_valid, cpu_data, bus_ack, bus_rdata
  );

  modport slave (
    input  cpu_rd, cpu_addr, bus_req, bus_write, bus_addr, bus_wdata,
    output cpu_stall, cpu_valid, cpu_data, bus_ack, bus_rdata
  );
endinterface

// File: rtl/dispatch_clear_seq.sv
// Ascending address counter for the post-reset RAM clear (used only with DISPATCH_CLEAR_EN).
module dispatch_clear_seq #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              active,
  output logic              done
);
  logic [ADDR_W-1:0] addr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg <= '0;
    end else if (start) begin
      addr_reg <= addr_reg + 1'b1;
    end else begin
      addr_reg <= '0;
    end
  end

  assign addr   = addr_reg;
  assign active = start;
  // Last address of the sweep is being written this cycle.
  assign done   = start && (&addr_reg);
endmodule

// File: rtl/dispatch_arbiter.sv
// Single-port dispatch RAM arbiter: CPU reads vs. bus read/write with starvation guard.
// Define DISPATCH_CLEAR_EN to zero the whole RAM after every reset.
module dispatch_arbiter
  import dispatch_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  dispatch_arbiter_if.slave   dif,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_data,
  output logic                ram_wren,
  output logic                ram_rden,
  input  logic [DATA_W-1:0]   ram_q,
  output logic                busy
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t            state_reg, state_next;
  logic [SW-1:0]     starve_reg, starve_next;
  logic              cpu_pend_reg;
  logic              bus_rd_reg;
  logic [DATA_W-1:0] bus_rdata_reg, bus_rdata_next;
  logic              cpu_grant, bus_grant, force_bus, stall, ack;
  logic [DATA_W-1:0] rdata_out;

`ifdef DISPATCH_CLEAR_EN
  logic              clr_start, clr_active, clr_done;
  logic [ADDR_W-1:0] clr_addr;

  dispatch_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk    (clk),
    .reset  (reset),
    .start  (clr_start),
    .addr   (clr_addr),
    .active (clr_active),
    .done   (clr_done)
  );
  assign busy = clr_active;
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DISPATCH_CLEAR_EN
      state_reg <= CLEAR;
`else
      state_reg <= RUN;
`endif
      starve_reg    <= '0;
      cpu_pend_reg  <= 1'b0;
      bus_rd_reg    <= 1'b0;
      bus_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      starve_reg    <= starve_next;
      cpu_pend_reg  <= cpu_grant;
      bus_rd_reg    <= bus_grant && !dif.bus_write;
      bus_rdata_reg <= bus_rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    starve_next = starve_reg;
    cpu_grant = 1'b0;
    bus_grant = 1'b0;
    force_bus = 1'b0;
    stall = 1'b0;
    ack = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    ram_rden = 1'b0;
`ifdef DISPATCH_CLEAR_EN
    clr_start = 1'b0;
`endif

    case (state_reg)
      CLEAR: begin
        starve_next = '0;
        stall = dif.cpu_rd;
`ifdef DISPATCH_CLEAR_EN
        clr_start = 1'b1;
        ram_addr = clr_addr;
        ram_wren = 1'b1;
        if (clr_done) state_next = RUN;
`else
        state_next = RUN;
`endif
      end
      RUN: begin
        force_bus = dif.bus_req && (starve_reg >= STARVE_LIM);
        cpu_grant = dif.cpu_rd && !force_bus;
        bus_grant = dif.bus_req && !cpu_grant;
        stall = dif.cpu_rd && !cpu_grant;
        starve_next = (!dif.bus_req || bus_grant) ? '0 : starve_reg + 1'b1;
        if (bus_grant) state_next = BUSACK;
      end
      BUSACK: begin
        // The bus cannot be granted back-to-back, but the CPU still gets the port.
        ack = 1'b1;
        cpu_grant = dif.cpu_rd;
        starve_next = '0;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    if (cpu_grant) begin
      ram_addr = dif.cpu_addr;
      ram_rden = 1'b1;
    end else if (bus_grant) begin
      ram_addr = dif.bus_addr;
      ram_wren = dif.bus_write;
      ram_rden = !dif.bus_write;
      ram_data = dif.bus_write ? dif.bus_wdata : '0;
    end

    bus_rdata_next = (state_reg == BUSACK && bus_rd_reg) ? ram_q : bus_rdata_reg;
    rdata_out = bus_rdata_next;

    // Outputs are forced quiet while reset is held, not just after the edge.
    if (reset) begin
      ram_addr = '0;
      ram_data = '0;
      ram_wren = 1'b0;
      ram_rden = 1'b0;
      stall = 1'b0;
      ack = 1'b0;
      cpu_grant = 1'b0;
      bus_grant = 1'b0;
      rdata_out = '0;
`ifdef DISPATCH_CLEAR_EN
      clr_start = 1'b0;
`endif
    end
  end

  assign dif.cpu_stall = stall;
  assign dif.bus_ack   = ack;
  assign dif.cpu_valid = cpu_pend_reg && !reset;
  assign dif.cpu_data  = (cpu_pend_reg && !reset) ? ram_q : '0;
  assign dif.bus_rdata = rdata_out;
endmodule

// File: tb/tb_dispatch_arbiter.sv
// Directed bench for dispatch_arbiter with a registered-output RAM model.
module tb_dispatch_arbiter;
  localparam int AW = 11;
  localparam int DW = 17;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dispatch_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q = '0;
  logic          ram_wren, ram_rden, busy;

  dispatch_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .dif      (dif),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .ram_rden (ram_rden),
    .ram_q    (ram_q),
    .busy     (busy)
  );

  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dif.cpu_rd = 1'b0;
    dif.cpu_addr = '0;
    dif.bus_req = 1'b0;
    dif.bus_write = 1'b0;
    dif.bus_addr = '0;
    dif.bus_wdata = '0;
  endtask

  // Walks the clear sweep (if built in), counting cycles and bad RAM writes.
  task automatic wait_clear(output int cycles, output int bad);
    cycles = 0;
    bad = 0;
`ifdef DISPATCH_CLEAR_EN
    while (busy && cycles < 3000) begin
      if (!(ram_wren && ram_data == '0 && int'(ram_addr) == cycles && !dif.cpu_stall == !dif.cpu_rd))
        bad++;
      cycles++;
      tick();
    end
`endif
  endtask

  int c, b;

  initial begin
    idle();
    dif.cpu_rd = 1'b1; dif.cpu_addr = 11'd5;
    dif.bus_req = 1'b1; dif.bus_write = 1'b1; dif.bus_addr = 11'd3; dif.bus_wdata = 17'd1;
    repeat (3) tick();
    check("rst_cpu_valid", dif.cpu_valid, 0);
    check("rst_cpu_data", dif.cpu_data, 0);
    check("rst_bus_ack", dif.bus_ack, 0);
    check("rst_bus_rdata", dif.bus_rdata, 0);
    check("rst_ram_wren", ram_wren, 0);
    check("rst_ram_rden", ram_rden, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_cpu_stall", dif.cpu_stall, 0);
    check("rst_busy", busy, 0);
    $display("[TB] reset held with requests active");

    idle();
    reset = 1'b0;
    #1;
`ifdef DISPATCH_CLEAR_EN
    check("clr_busy_first", busy, 1);
    wait_clear(c, b);
    check("clr_len", c, 2048);
    check("clr_writes", b, 0);
    $display("[TB] clear sweep %0d cycles", c);
`endif
    check("busy_after_reset", busy, 0);

    // RUN must accept a CPU read straight away
    dif.cpu_rd = 1'b1; dif.cpu_addr = 11'd0;
    #1;
    check("run_first_rden", ram_rden, 1);
    check("run_first_stall", dif.cpu_stall, 0);
    tick();
    dif.cpu_rd = 1'b0;
    #1;
    check("run_first_valid", dif.cpu_valid, 1);
    tick();
    #1;
    check("run_valid_pulse", dif.cpu_valid, 0);

    // Bus write 0o100 <- 0o12345 then bus read back
    dif.bus_req = 1'b1; dif.bus_write = 1'b1; dif.bus_addr = 11'o100; dif.bus_wdata = 17'o12345;
    #1;
    check("bw_wren", ram_wren, 1);
    check("bw_addr", ram_addr, 11'o100);
    check("bw_data", ram_data, 17'o12345);
    check("bw_no_ack_g", dif.bus_ack, 0);
    tick();
    #1;
    check("bw_ack", dif.bus_ack, 1);
    check("bw_busack_ignored", ram_wren, 0);
    tick();
    idle();
    #1;
    check("bw_ack_pulse", dif.bus_ack, 0);
    $display("[TB] bus write addr %0o data %0o", 11'o100, 17'o12345);
    dif.bus_req = 1'b1; dif.bus_write = 1'b0; dif.bus_addr = 11'o100;
    #1;
    check("br_rden", ram_rden, 1);
    check("br_addr", ram_addr, 11'o100);
    tick();
    #1;
    check("br_ack", dif.bus_ack, 1);
    check("br_rdata", dif.bus_rdata, 17'o12345);
    tick();
    idle();
    #1;
    check("br_ack_pulse", dif.bus_ack, 0);
    check("br_rdata_hold1", dif.bus_rdata, 17'o12345);
    tick();
    #1;
    check("br_rdata_hold2", dif.bus_rdata, 17'o12345);
    $display("[TB] bus read addr %0o data %0o", 11'o100, dif.bus_rdata);

    // Bus write addr 5 <- 7, CPU read of addr 5 during the ack cycle
    dif.bus_req = 1'b1; dif.bus_write = 1'b1; dif.bus_addr = 11'd5; dif.bus_wdata = 17'd7;
    tick();
    dif.cpu_rd = 1'b1; dif.cpu_addr = 11'd5;
    #1;
    check("raw_cpu_rden", ram_rden, 1);
    check("raw_cpu_addr", ram_addr, 5);
    check("raw_cpu_stall", dif.cpu_stall, 0);
    tick();
    idle();
    #1;
    check("raw_valid", dif.cpu_valid, 1);
    check("raw_data", dif.cpu_data, 7);
    tick();
    #1;
    check("raw_valid_pulse", dif.cpu_valid, 0);
    $display("[TB] write-then-read addr 5 data 7");

    // Starvation: CPU reads continuously, bus request arrives at T
    dif.cpu_rd = 1'b1; dif.cpu_addr = 11'o100;
    dif.bus_req = 1'b1; dif.bus_write = 1'b1; dif.bus_addr = 11'd9; dif.bus_wdata = 17'h1abc;
    for (int i = 0; i < SMAX; i++) begin
      #1;
      check($sformatf("starve_rden_%0d", i), ram_rden, 1);
      check($sformatf("starve_stall_%0d", i), dif.cpu_stall, 0);
      tick();
    end
    #1;
    check("starve_force_stall", dif.cpu_stall, 1);
    check("starve_force_wren", ram_wren, 1);
    check("starve_force_addr", ram_addr, 9);
    tick();
    #1;
    check("starve_ack", dif.bus_ack, 1);
    check("starve_no_valid", dif.cpu_valid, 0);
    check("starve_ack_stall", dif.cpu_stall, 0);
    check("starve_ack_cpu_addr", ram_addr, 11'o100);
    tick();
    dif.bus_req = 1'b0;
    #1;
    check("starve_valid", dif.cpu_valid, 1);
    check("starve_data", dif.cpu_data, 17'o12345);
    idle();
    tick();
    $display("[TB] starvation grant after %0d denied cycles", SMAX);

    // Reset clears a partly advanced starvation counter
    dif.cpu_rd = 1'b1; dif.cpu_addr = 11'd5;
    dif.bus_req = 1'b1; dif.bus_write = 1'b0; dif.bus_addr = 11'd5;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    wait_clear(c, b);
    for (int i = 0; i < SMAX; i++) begin
      #1;
      check($sformatf("rst_starve_stall_%0d", i), dif.cpu_stall, 0);
      tick();
    end
    #1;
    check("rst_starve_force", dif.cpu_stall, 1);
    tick();
    tick();
    idle();
    tick();
    $display("[TB] starvation counter cleared by reset");

    // Reset during BUSACK of a bus read: no ack, RUN (or clear) next
    dif.bus_req = 1'b1; dif.bus_write = 1'b0; dif.bus_addr = 11'o100;
    #1;
    check("rb_rden", ram_rden, 1);
    tick();
    reset = 1'b1;
    #1;
    check("rb_no_ack", dif.bus_ack, 0);
    tick();
    reset = 1'b0;
    idle();
    dif.cpu_rd = 1'b1; dif.cpu_addr = 11'd5;
    #1;
    check("rb_after_ack", dif.bus_ack, 0);
`ifdef DISPATCH_CLEAR_EN
    check("rb_clear_busy", busy, 1);
    check("rb_clear_addr0", ram_addr, 0);
    wait_clear(c, b);
    check("rb_clear_len", c, 2048);
`else
    check("rb_run_rden", ram_rden, 1);
    check("rb_run_stall", dif.cpu_stall, 0);
`endif
    idle();
    tick();
    $display("[TB] reset during bus ack");

    // Reset with a CPU read outstanding: valid never appears
    dif.cpu_rd = 1'b1; dif.cpu_addr = 11'd5;
    tick();
    idle();
    reset = 1'b1;
    #1;
    check("rc_no_valid", dif.cpu_valid, 0);
    tick();
    reset = 1'b0;
    #1;
    check("rc_no_valid_after", dif.cpu_valid, 0);
    wait_clear(c, b);
    $display("[TB] reset with cpu read outstanding");

`ifdef DISPATCH_CLEAR_EN
    // Reset at clear address 1000 restarts the sweep at 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (1000) tick();
    #1;
    check("ca_addr1000", ram_addr, 1000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("ca_restart_addr", ram_addr, 0);
    wait_clear(c, b);
    check("ca_len", c, 2048);
    check("ca_writes", b, 0);
    $display("[TB] clear aborted at 1000 and restarted");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
